// File: rtl/regfile_writeback_unit.sv
// rtl/regfile_writeback_unit.sv - register-file write-port producer: ALU/long-latency merge, result FIFO, scoreboard
//
// Merges single-cycle ALU results with buffered long-latency results (load,
// mul/div) into one registered register-file write stream. It also keeps a
// destination scoreboard that decode uses to stall on pending registers.
//
// Ports:
//   i_clk, i_arst                          clock; asynchronous active-high reset
//   i_alu_valid/o_alu_ready/i_alu_addr/i_alu_data
//                                          single-cycle ALU result handshake
//   i_ll_valid/o_ll_ready/i_ll_addr/i_ll_data
//                                          long-latency result handshake (buffered)
//   i_reserve_en/i_reserve_addr            mark a long-latency destination busy at issue
//   i_rs1_addr/i_rs2_addr, o_stall         decode source check against the scoreboard
//   o_busy                                 scoreboard vector
//   o_write_en_3/o_addr_3/o_write_data_3   registered register-file write port
module regfile_writeback_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_DEPTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [ADDR_WIDTH-1:0] i_alu_addr,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    input  logic                  i_ll_valid,
    output logic                  o_ll_ready,
    input  logic [ADDR_WIDTH-1:0] i_ll_addr,
    input  logic [DATA_WIDTH-1:0] i_ll_data,
    input  logic                  i_reserve_en,
    input  logic [ADDR_WIDTH-1:0] i_reserve_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
    output logic                  o_stall,
    output logic [REG_DEPTH-1:0]  o_busy,
    output logic                  o_write_en_3,
    output logic [ADDR_WIDTH-1:0] o_addr_3,
    output logic [DATA_WIDTH-1:0] o_write_data_3
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;

    logic                  full;
    logic                  empty;
    logic                  alu_take;
    logic                  ll_push;
    logic                  ll_pop;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [REG_DEPTH-1:0]  busy_next;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // Both producers are held off while the buffer is full. Holding the ALU
    // back guarantees the arbiter pops, so a steady ALU stream cannot starve
    // the long-latency results.
    assign o_ll_ready  = !full;
    assign o_alu_ready = !full;

    assign alu_take = i_alu_valid && !full;
    assign ll_push  = i_ll_valid && !full;
    assign ll_pop   = !alu_take && !empty;

    // ALU has priority; otherwise drain the buffer head.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        if (alu_take) begin
            sel_valid = 1'b1;
            sel_addr  = i_alu_addr;
            sel_data  = i_alu_data;
        end else if (ll_pop) begin
            sel_valid = 1'b1;
            sel_addr  = head_addr;
            sel_data  = head_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (ll_push) begin
            fifo_addr[wr_ptr] <= i_ll_addr;
            fifo_data[wr_ptr] <= i_ll_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (ll_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ll_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (ll_push && !ll_pop) begin
                count <= count + CNT_ONE;
            end else if (ll_pop && !ll_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // The clear is applied before the set so a same-cycle reserve of the
    // popped destination keeps the bit busy. x0 is never reserved.
    always_comb begin
        busy_next = o_busy;
        if (ll_pop) begin
            busy_next[head_addr] = 1'b0;
        end
        if (i_reserve_en && (i_reserve_addr != '0)) begin
            busy_next[i_reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_busy <= '0;
        end else begin
            o_busy <= busy_next;
        end
    end

    assign o_stall = o_busy[i_rs1_addr] | o_busy[i_rs2_addr];

    // Idle and x0 writes drive all-zero outputs: the register file bypasses on
    // any read address matching addr_3, so a parked address must be x0.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_write_en_3   <= 1'b0;
            o_addr_3       <= '0;
            o_write_data_3 <= '0;
        end else if (sel_valid && (sel_addr != '0)) begin
            o_write_en_3   <= 1'b1;
            o_addr_3       <= sel_addr;
            o_write_data_3 <= sel_data;
        end else begin
            o_write_en_3   <= 1'b0;
            o_addr_3       <= '0;
            o_write_data_3 <= '0;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb/tb_regfile_writeback_unit.sv - self-checking bench for regfile_writeback_unit
module tb_regfile_writeback_unit;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int RD = 32;
    localparam int FD = 4;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_alu_valid;
    logic          o_alu_ready;
    logic [AW-1:0] i_alu_addr;
    logic [DW-1:0] i_alu_data;
    logic          i_ll_valid;
    logic          o_ll_ready;
    logic [AW-1:0] i_ll_addr;
    logic [DW-1:0] i_ll_data;
    logic          i_reserve_en;
    logic [AW-1:0] i_reserve_addr;
    logic [AW-1:0] i_rs1_addr;
    logic [AW-1:0] i_rs2_addr;
    logic          o_stall;
    logic [RD-1:0] o_busy;
    logic          o_write_en_3;
    logic [AW-1:0] o_addr_3;
    logic [DW-1:0] o_write_data_3;

    regfile_writeback_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_DEPTH(RD), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_addr(i_alu_addr), .i_alu_data(i_alu_data),
        .i_ll_valid(i_ll_valid), .o_ll_ready(o_ll_ready),
        .i_ll_addr(i_ll_addr), .i_ll_data(i_ll_data),
        .i_reserve_en(i_reserve_en), .i_reserve_addr(i_reserve_addr),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_stall(o_stall), .o_busy(o_busy),
        .o_write_en_3(o_write_en_3), .o_addr_3(o_addr_3),
        .o_write_data_3(o_write_data_3)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [RD-1:0] m_busy;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            m_alu_acc;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic reset_model();
        q.delete();
        m_busy    = '0;
        e_we      = 1'b0;
        e_addr    = '0;
        e_data    = '0;
        m_alu_acc = 0;
    endtask

    // Drive one cycle of inputs, advance the reference model, then move to
    // 1 time unit after the clock edge where outputs are sampled.
    task automatic apply(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input bit re, input logic [AW-1:0] ra);
        bit   is_full;
        ent_t e;
        i_alu_valid    = av;
        i_alu_addr     = aa;
        i_alu_data     = ad;
        i_ll_valid     = lv;
        i_ll_addr      = la;
        i_ll_data      = ld;
        i_reserve_en   = re;
        i_reserve_addr = ra;
        is_full = (q.size() == FD);
        e_we = 1'b0; e_addr = '0; e_data = '0;
        if (av && !is_full) begin
            m_alu_acc++;
            if (aa != 0) begin e_we = 1'b1; e_addr = aa; e_data = ad; end
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_busy[e.a] = 1'b0;
            if (e.a != 0) begin e_we = 1'b1; e_addr = e.a; e_data = e.d; end
        end
        if (lv && !is_full) begin
            e.a = la; e.d = ld;
            q.push_back(e);
        end
        if (re && ra != 0) m_busy[ra] = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        i_arst = 1'b1;
        i_rs1_addr = '0; i_rs2_addr = '0;
        i_alu_valid = 0; i_alu_addr = 0; i_alu_data = 0;
        i_ll_valid = 0; i_ll_addr = 0; i_ll_data = 0;
        i_reserve_en = 0; i_reserve_addr = 0;
        reset_model();
        repeat (2) @(posedge i_clk);
        #1;
        n_cmp++; if (o_write_en_3 !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", o_write_en_3); end
        n_cmp++; if (o_addr_3 !== '0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", o_addr_3); end
        n_cmp++; if (o_write_data_3 !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", o_write_data_3); end
        n_cmp++; if (o_busy !== '0) begin n_fail++; $display("FAIL reset_busy got=%h exp=0", o_busy); end
        n_cmp++; if (o_ll_ready !== 1'b1 || o_alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b%b exp=11", o_ll_ready, o_alu_ready); end
        n_cmp++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
        i_arst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_alu_write();
        apply(1, 5, 64'hDEAD, 0, 0, 0, 0, 0);
        n_cmp++; if (o_write_en_3 !== 1'b1 || o_addr_3 !== 5 || o_write_data_3 !== 64'hDEAD) begin
            n_fail++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/dead", o_write_en_3, o_addr_3, o_write_data_3);
        end
        idle();
        n_cmp++; if (o_write_en_3 !== 1'b0 || o_addr_3 !== 0 || o_write_data_3 !== 0) begin
            n_fail++; $display("FAIL alu_idle got=%b/%0d/%h exp=0/0/0", o_write_en_3, o_addr_3, o_write_data_3);
        end
    endtask

    task automatic test_reserve_ll();
        apply(0, 0, 0, 0, 0, 0, 1, 7);
        i_rs1_addr = 7;
        #1;
        n_cmp++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL reserve_stall got=%b exp=1", o_stall); end
        apply(0, 0, 0, 1, 7, 64'h42, 0, 0);
        n_cmp++; if (o_busy[7] !== 1'b1 || o_stall !== 1'b1) begin n_fail++; $display("FAIL ll_pending got=%b/%b exp=1/1", o_busy[7], o_stall); end
        idle();
        n_cmp++; if (o_write_en_3 !== 1'b1 || o_addr_3 !== 7 || o_write_data_3 !== 64'h42) begin
            n_fail++; $display("FAIL ll_write got=%b/%0d/%h exp=1/7/42", o_write_en_3, o_addr_3, o_write_data_3);
        end
        n_cmp++; if (o_busy[7] !== 1'b0 || o_stall !== 1'b0) begin n_fail++; $display("FAIL ll_clear got=%b/%b exp=0/0", o_busy[7], o_stall); end
        i_rs1_addr = 0;
    endtask

    task automatic test_fill_drain();
        logic [AW-1:0] ll_seen[$];
        int alu_seen = 0;
        int acc0 = m_alu_acc;
        for (int i = 0; i < FD; i++) begin
            apply(1, 10, 64'h1000 + i, 1, AW'(20 + i), 64'h2000 + i, 0, 0);
            if (o_addr_3 == 10) alu_seen++;
            if (o_addr_3 >= 20) ll_seen.push_back(o_addr_3);
        end
        n_cmp++; if (o_ll_ready !== 1'b0 || o_alu_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_ready got=%b%b exp=00", o_ll_ready, o_alu_ready);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1, 10, 64'h3000 + i, 0, 0, 0, 0, 0);
            if (o_addr_3 == 10) alu_seen++;
            if (o_addr_3 >= 20) ll_seen.push_back(o_addr_3);
            if (i == 0) begin
                n_cmp++; if (o_ll_ready !== 1'b1 || o_alu_ready !== 1'b1) begin
                    n_fail++; $display("FAIL unfull_ready got=%b%b exp=11", o_ll_ready, o_alu_ready);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            idle();
            if (o_addr_3 == 10) alu_seen++;
            if (o_addr_3 >= 20) ll_seen.push_back(o_addr_3);
        end
        n_cmp++; if (ll_seen.size() != FD) begin
            n_fail++; $display("FAIL drain_count got=%0d exp=%0d", ll_seen.size(), FD);
        end else begin
            for (int i = 0; i < FD; i++) begin
                n_cmp++; if (ll_seen[i] !== AW'(20 + i)) begin
                    n_fail++; $display("FAIL drain_order[%0d] got=%0d exp=%0d", i, ll_seen[i], 20 + i);
                end
            end
        end
        n_cmp++; if (alu_seen != m_alu_acc - acc0 || alu_seen != 6) begin
            n_fail++; $display("FAIL alu_count got=%0d exp=6", alu_seen);
        end
    endtask

    task automatic test_set_clear();
        apply(0, 0, 0, 1, 9, 64'h99, 1, 9);
        apply(0, 0, 0, 0, 0, 0, 1, 9);
        n_cmp++; if (o_write_en_3 !== 1'b1 || o_addr_3 !== 9) begin
            n_fail++; $display("FAIL setclr_write got=%b/%0d exp=1/9", o_write_en_3, o_addr_3);
        end
        n_cmp++; if (o_busy[9] !== 1'b1) begin n_fail++; $display("FAIL setclr_busy9 got=%b exp=1", o_busy[9]); end
        apply(0, 0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (o_busy !== m_busy || o_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL reserve_x0 got=%h exp=%h", o_busy, m_busy);
        end
    endtask

    task automatic test_x0();
        apply(0, 0, 0, 1, 0, 64'hABC, 0, 0);
        idle();
        n_cmp++; if (o_write_en_3 !== 1'b0 || o_addr_3 !== 0 || o_write_data_3 !== 0) begin
            n_fail++; $display("FAIL ll_x0 got=%b/%0d/%h exp=0/0/0", o_write_en_3, o_addr_3, o_write_data_3);
        end
        n_cmp++; if (q.size() != 0 || o_ll_ready !== 1'b1) begin
            n_fail++; $display("FAIL ll_x0_consumed model=%0d ready=%b exp=0/1", q.size(), o_ll_ready);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) apply(1, 11, 64'h55, 1, AW'(12 + i), 64'h77, 1, AW'(12 + i));
        i_alu_valid = 0; i_ll_valid = 0; i_reserve_en = 0;
        n_cmp++; if (o_write_en_3 !== 1'b1 || o_busy === '0) begin
            n_fail++; $display("FAIL prereset_state got=%b/%h exp=1/nonzero", o_write_en_3, o_busy);
        end
        #2;
        i_arst = 1'b1;
        #1;
        n_cmp++; if (o_write_en_3 !== 0 || o_addr_3 !== 0 || o_write_data_3 !== 0 || o_busy !== 0) begin
            n_fail++; $display("FAIL async_reset got=%b/%0d/%h/%h exp=0/0/0/0", o_write_en_3, o_addr_3, o_write_data_3, o_busy);
        end
        @(posedge i_clk); #1;
        i_arst = 1'b0;
        reset_model();
        for (int i = 0; i < 3; i++) begin
            idle();
            n_cmp++; if (o_write_en_3 !== 1'b0 || o_addr_3 !== 0) begin
                n_fail++; $display("FAIL post_reset_write[%0d] got=%b/%0d exp=0/0", i, o_write_en_3, o_addr_3);
            end
        end
        n_cmp++; if (o_ll_ready !== 1'b1 || o_busy !== 0) begin
            n_fail++; $display("FAIL post_reset_empty got=%b/%h exp=1/0", o_ll_ready, o_busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_rs1_addr = AW'($urandom);
            i_rs2_addr = AW'($urandom);
            apply(($urandom_range(0, 99) < 40), AW'($urandom_range(0, 7)), {$urandom, $urandom},
                  ($urandom_range(0, 99) < 50), AW'($urandom_range(0, 31)), {$urandom, $urandom},
                  ($urandom_range(0, 99) < 30), AW'($urandom));
            n_cmp++; if (o_write_en_3 !== e_we || o_addr_3 !== e_addr || o_write_data_3 !== e_data) begin
                n_fail++; $display("FAIL rnd_write c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, o_write_en_3, o_addr_3, o_write_data_3, e_we, e_addr, e_data);
            end
            n_cmp++; if (o_busy !== m_busy || o_stall !== (m_busy[i_rs1_addr] | m_busy[i_rs2_addr])) begin
                n_fail++; $display("FAIL rnd_busy c=%0d got=%h/%b exp=%h", c, o_busy, o_stall, m_busy);
            end
            n_cmp++; if (o_ll_ready !== (q.size() < FD) || o_alu_ready !== (q.size() < FD)) begin
                n_fail++; $display("FAIL rnd_ready c=%0d got=%b%b exp_size=%0d", c, o_ll_ready, o_alu_ready, q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_reserve_ll();
        test_fill_drain();
        test_set_clear();
        test_x0();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
